// File: rtl/dcc_supervisor.sv
// dcc_supervisor: sequences the DCC reset, qualifies lock over a stability window and retries a bounded number of times.
// Optional periodic recalibration from READY is compiled in when DCC_RECAL_EN is defined.
module dcc_supervisor #(
    parameter int RST_CYC      = 4,
    parameter int TIMEOUT      = 64,
    parameter int STABLE_CYC   = 8,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 8,
    parameter int RECAL_PERIOD = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             locked_in,
    output logic                             dcc_rst_n,
    output logic                             dcc_ready,
    output logic                             dcc_fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
    output logic [CNT_W-1:0]                 lock_cycles
);
    localparam int RW     = $clog2(MAX_RETRY + 1);
    localparam int MAX_AB = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
    localparam int MAXC   = (MAX_AB > STABLE_CYC) ? MAX_AB : STABLE_CYC;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int LC_MAX = (1 << CNT_W) - 1;

    typedef enum logic [2:0] {IDLE, RESET, WAIT_LOCK, STABLE, READY, FAIL} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          retry, recal, rc_done;

`ifdef DCC_RECAL_EN
    localparam int RCW = $clog2(RECAL_PERIOD + 1);
    logic [RCW-1:0] rc;
    assign rc_done = rc == RCW'(RECAL_PERIOD - 1);

    // recalibration timer: counts cycles spent in READY, restarts on every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rc <= '0;
        else     rc <= (state == READY && state_nx == READY) ? rc + 1'b1 : '0;
    end
`else
    // recalibration compiled out: the period can never expire
    assign rc_done = RECAL_PERIOD < 0;
`endif

    // next-state decode; enable=0 overrides everything, lost lock beats recalibration
    always_comb begin
        state_nx = state;
        retry    = 1'b0;
        recal    = 1'b0;
        if (!enable) state_nx = IDLE;
        else begin
            case (state)
                IDLE:      state_nx = RESET;
                RESET:     if (cnt == CW'(RST_CYC - 1)) state_nx = WAIT_LOCK;
                WAIT_LOCK: if (locked_in) state_nx = STABLE;
                           else retry = cnt == CW'(TIMEOUT - 1);
                STABLE:    if (!locked_in) retry = 1'b1;
                           else if (cnt == CW'(STABLE_CYC - 1)) state_nx = READY;
                READY:     if (!locked_in) retry = 1'b1;
                           else if (rc_done) begin
                               state_nx = RESET;
                               recal    = 1'b1;
                           end
                FAIL:      state_nx = FAIL;
                default:   state_nx = IDLE;
            endcase
            if (retry) state_nx = (retry_cnt == RW'(MAX_RETRY)) ? FAIL : RESET;
        end
    end

    // state, phase counter and outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dcc_rst_n   <= 1'b0;
            dcc_ready   <= 1'b0;
            dcc_fail    <= 1'b0;
            retry_cnt   <= '0;
            lock_cycles <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= (state_nx != state) ? '0 : cnt + 1'b1;
            dcc_rst_n <= state_nx inside {WAIT_LOCK, STABLE, READY};
            dcc_ready <= state_nx == READY;
            dcc_fail  <= state_nx == FAIL;
            if ((state == IDLE && state_nx == RESET) || recal) retry_cnt <= '0;
            else if (retry && state_nx == RESET)               retry_cnt <= retry_cnt + 1'b1;
            if (state == WAIT_LOCK && state_nx == STABLE)
                lock_cycles <= (32'(cnt) > LC_MAX) ? '1 : CNT_W'(cnt);
        end
    end
endmodule

// File: tb/tb_dcc_supervisor.sv
// tb_dcc_supervisor: directed scenarios with a phase/elapsed-time model checked every cycle plus literal expectations.
// Build with DCC_RECAL_EN defined to include the periodic recalibration scenario.
module tb_dcc_supervisor;
    localparam int RST_CYC = 4, TIMEOUT = 64, STABLE_CYC = 8, MAX_RETRY = 3, CNT_W = 8, RECAL_PERIOD = 4096;
    localparam int P_OFF = 0, P_RES = 1, P_WAIT = 2, P_QUAL = 3, P_READY = 4, P_FAIL = 5;

    logic       clk = 1'b0;
    logic       rst, enable, locked_in;
    logic       dcc_rst_n, dcc_ready, dcc_fail;
    logic [1:0] retry_cnt;
    logic [7:0] lock_cycles;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        int ph;
        int age;
        int retries;
        int lockc;
    } mdl_t;
    mdl_t m;

    dcc_supervisor #(
        .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT), .STABLE_CYC(STABLE_CYC),
        .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W), .RECAL_PERIOD(RECAL_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .locked_in(locked_in),
        .dcc_rst_n(dcc_rst_n), .dcc_ready(dcc_ready), .dcc_fail(dcc_fail),
        .retry_cnt(retry_cnt), .lock_cycles(lock_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic mdl_t go(mdl_t c, int ph);
        mdl_t n;
        n     = c;
        n.ph  = ph;
        n.age = 0;
        return n;
    endfunction

    // a failed or lost attempt either burns one retry or ends the session
    function automatic mdl_t lose(mdl_t c);
        mdl_t n;
        n = c;
        if (c.retries >= MAX_RETRY) return go(n, P_FAIL);
        n.retries = c.retries + 1;
        return go(n, P_RES);
    endfunction

    // one clock of the model: age is the number of cycles spent in the phase including this one
    function automatic mdl_t step(mdl_t c, logic en, logic lk);
        mdl_t n;
        n     = c;
        n.age = c.age + 1;
        if (!en) return go(n, P_OFF);
        case (c.ph)
            P_OFF: begin
                n         = go(n, P_RES);
                n.retries = 0;
            end
            P_RES:  if (n.age == RST_CYC) n = go(n, P_WAIT);
            P_WAIT: if (lk) begin
                        n.lockc = (c.age > 255) ? 255 : c.age;
                        n       = go(n, P_QUAL);
                    end else if (n.age == TIMEOUT) n = lose(n);
            P_QUAL: if (!lk) n = lose(n);
                    else if (n.age == STABLE_CYC) n = go(n, P_READY);
            P_READY: begin
                if (!lk) n = lose(n);
`ifdef DCC_RECAL_EN
                else if (n.age == RECAL_PERIOD) begin
                    n         = go(n, P_RES);
                    n.retries = 0;
                end
`endif
            end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{P_OFF, 0, 0, 0};
        else     m <= step(m, enable, locked_in);
    end

    always @(negedge clk) begin
        chk("rst_n", int'(dcc_rst_n), int'(m.ph == P_WAIT || m.ph == P_QUAL || m.ph == P_READY));
        chk("ready", int'(dcc_ready), int'(m.ph == P_READY));
        chk("fail", int'(dcc_fail), int'(m.ph == P_FAIL));
        chk("retry_cnt", int'(retry_cnt), m.retries);
        chk("lock_cycles", int'(lock_cycles), m.lockc);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; locked_in = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("L_reset_rst_n", int'(dcc_rst_n), 0);
        chk("L_reset_ready", int'(dcc_ready), 0);
        chk("L_reset_fail", int'(dcc_fail), 0);
        chk("L_reset_retry", int'(retry_cnt), 0);
        chk("L_reset_lockc", int'(lock_cycles), 0);
        tick(2);
        rst = 1'b0;
        // clean lock: locked_in first sampled high after 20 unlocked cycles
        enable = 1'b1;
        tick(4);  chk("L_clean_rst_low", int'(dcc_rst_n), 0);
        tick(1);  chk("L_clean_rst_high", int'(dcc_rst_n), 1);
        tick(20); locked_in = 1'b1;
        tick(1);  chk("L_clean_lockc", int'(lock_cycles), 20);
        tick(7);  chk("L_clean_not_ready", int'(dcc_ready), 0);
        tick(1);  chk("L_clean_ready", int'(dcc_ready), 1);
        chk("L_clean_retry", int'(retry_cnt), 0);
        // glitch three cycles into STABLE
        enable = 1'b0; locked_in = 1'b0;
        tick(2);  enable = 1'b1;
        tick(5);  locked_in = 1'b1;
        tick(1);
        tick(3);  locked_in = 1'b0;
        tick(1);  chk("L_glitch_retry", int'(retry_cnt), 1);
        chk("L_glitch_rst_n", int'(dcc_rst_n), 0);
        locked_in = 1'b1;
        tick(3);  chk("L_glitch_rst_hold", int'(dcc_rst_n), 0);
        tick(1);  chk("L_glitch_rst_rel", int'(dcc_rst_n), 1);
        tick(9);  chk("L_glitch_ready", int'(dcc_ready), 1);
        // lost lock in READY
        locked_in = 1'b0;
        tick(1);  chk("L_lost_ready", int'(dcc_ready), 0);
        chk("L_lost_rst_n", int'(dcc_rst_n), 0);
        chk("L_lost_retry", int'(retry_cnt), 2);
        locked_in = 1'b1;
        tick(13); chk("L_relock_ready", int'(dcc_ready), 1);
        // asynchronous reset between edges while READY
        rst = 1'b1;
        #1;
        chk("L_arst_ready", int'(dcc_ready), 0);
        chk("L_arst_rst_n", int'(dcc_rst_n), 0);
        chk("L_arst_retry", int'(retry_cnt), 0);
        chk("L_arst_lockc", int'(lock_cycles), 0);
        tick(2);  rst = 1'b0;
        tick(1);  chk("L_arst_resume_low", int'(dcc_rst_n), 0);
        tick(4);  chk("L_arst_resume_high", int'(dcc_rst_n), 1);
        // never locks: four attempts then FAIL
        enable = 1'b0; locked_in = 1'b0;
        tick(2);  enable = 1'b1;
        tick(4);  chk("L_nolock_rst_low", int'(dcc_rst_n), 0);
        tick(1);  chk("L_nolock_rst_high", int'(dcc_rst_n), 1);
        tick(63); chk("L_nolock_last_high", int'(dcc_rst_n), 1);
        tick(1);  chk("L_nolock_timeout", int'(dcc_rst_n), 0);
        chk("L_nolock_retry1", int'(retry_cnt), 1);
        tick(203); chk("L_nolock_not_fail", int'(dcc_fail), 0);
        tick(1);  chk("L_nolock_fail", int'(dcc_fail), 1);
        chk("L_nolock_retry3", int'(retry_cnt), 3);
        chk("L_nolock_rst_n", int'(dcc_rst_n), 0);
        tick(5);  chk("L_fail_sticky", int'(dcc_fail), 1);
        // leaving FAIL holds retry_cnt; a new session clears it; abort inside WAIT_LOCK
        enable = 1'b0;
        tick(1);  chk("L_idle_fail", int'(dcc_fail), 0);
        chk("L_idle_retry_hold", int'(retry_cnt), 3);
        tick(2);  enable = 1'b1;
        tick(1);  chk("L_session_retry", int'(retry_cnt), 0);
        tick(4);  chk("L_abort_wait", int'(dcc_rst_n), 1);
        tick(10); enable = 1'b0;
        tick(1);  chk("L_abort_rst_n", int'(dcc_rst_n), 0);
`ifdef DCC_RECAL_EN
        // periodic recalibration after RECAL_PERIOD cycles in READY
        tick(2);  enable = 1'b1; locked_in = 1'b1;
        tick(14); chk("L_recal_ready", int'(dcc_ready), 1);
        tick(RECAL_PERIOD - 1); chk("L_recal_still", int'(dcc_ready), 1);
        tick(1);  chk("L_recal_drop", int'(dcc_ready), 0);
        chk("L_recal_rst_n", int'(dcc_rst_n), 0);
        chk("L_recal_retry", int'(retry_cnt), 0);
        tick(3);  chk("L_recal_rst_hold", int'(dcc_rst_n), 0);
        tick(1);  chk("L_recal_rst_rel", int'(dcc_rst_n), 1);
        tick(9);  chk("L_recal_relock", int'(dcc_ready), 1);
        chk("L_recal_retry_end", int'(retry_cnt), 0);
`endif
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
